// File: rtl/detector_arbiter.sv
// detector_arbiter: round-robin sharing of one serial pattern detector among
// CH bit-stream requesters. Each channel keeps its own partial-match progress,
// so every stream behaves as if it owned a private Mealy detector.
module detector_arbiter #(
    parameter int CH = 4,
    parameter int PLEN = 3,
    parameter logic [PLEN-1:0] PATTERN = 3'b111
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic [CH-1:0] req,
    input  logic [CH-1:0] bit_in,
    output logic [CH-1:0] grant,
    output logic          found,
    output logic [2:0]    found_ch,
    output logic [7:0]    match_count
);

    localparam int PW = (CH > 1) ? $clog2(CH) : 1;

    logic [2:0]    prog [CH];
    logic [PW-1:0] ptr;

    logic          sel_valid;
    logic [PW-1:0] sel;
    logic [2:0]    sel_prog;
    logic          sel_bit;
    logic          want_bit;
    logic          hit;
    logic [2:0]    next_prog;

    // Pick the first eligible requester after the last granted one; a channel
    // granted at the previous edge is masked so a held bit is not consumed twice.
    always_comb begin
        int idx;
        sel_valid = 1'b0;
        sel       = ptr;
        for (int k = 1; k <= CH; k++) begin
            idx = int'(ptr) + k;
            if (idx >= CH) idx = idx - CH;
            if (!sel_valid && req[idx] && !grant[idx]) begin
                sel_valid = 1'b1;
                sel       = PW'(idx);
            end
        end
    end

    // Shared detector datapath: compare the selected channel's bit with the
    // pattern bit it is waiting for and work out its next progress value.
    always_comb begin
        sel_prog  = prog[sel];
        sel_bit   = bit_in[sel];
        want_bit  = PATTERN[PLEN-1-int'(sel_prog)];
        hit       = 1'b0;
        next_prog = 3'd0;
        if (sel_bit == want_bit) begin
            if (int'(sel_prog) == PLEN-1) begin
                hit       = 1'b1;
                next_prog = 3'd0;
            end else begin
                next_prog = sel_prog + 3'd1;
            end
        end else begin
            next_prog = (sel_bit == PATTERN[PLEN-1]) ? 3'd1 : 3'd0;
        end
    end

    // Registered arbitration and detection results; flush beats arbitration
    // and keeps the round-robin pointer and the running match total.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CH; i++) prog[i] <= 3'd0;
            ptr         <= PW'(CH-1);
            grant       <= '0;
            found       <= 1'b0;
            found_ch    <= 3'd0;
            match_count <= 8'd0;
        end else if (flush) begin
            for (int i = 0; i < CH; i++) prog[i] <= 3'd0;
            grant    <= '0;
            found    <= 1'b0;
            found_ch <= 3'd0;
        end else if (sel_valid) begin
            grant <= {{(CH-1){1'b0}}, 1'b1} << sel;
            ptr   <= sel;
            for (int i = 0; i < CH; i++) begin
                if (PW'(i) == sel) prog[i] <= next_prog;
            end
            found <= hit;
            if (hit) begin
                found_ch <= 3'(sel);
                if (match_count != 8'hFF) match_count <= match_count + 8'd1;
            end
        end else begin
            grant <= '0;
            found <= 1'b0;
        end
    end

endmodule

// File: tb/tb_detector_arbiter.sv
// tb_detector_arbiter: directed tests for detector_arbiter with a behavioural
// reference model compared against the DUT on every falling clock edge.
module tb_detector_arbiter;

    localparam int CH = 4;
    localparam int PLEN = 3;
    localparam logic [PLEN-1:0] PAT = 3'b111;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic [CH-1:0] req;
    logic [CH-1:0] bit_in;
    logic [CH-1:0] grant;
    logic          found;
    logic [2:0]    found_ch;
    logic [7:0]    match_count;

    int errors = 0;
    int checks = 0;

    detector_arbiter #(.CH(CH), .PLEN(PLEN), .PATTERN(PAT)) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .req(req),
        .bit_in(bit_in),
        .grant(grant),
        .found(found),
        .found_ch(found_ch),
        .match_count(match_count)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Reference model state: how many pattern bits each stream has matched,
    // who was served last, and what the outputs must show.
    int m_prog [CH];
    int m_ptr;
    int m_last;
    int m_grant;
    int m_found;
    int m_fch;
    int m_count;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [CH-1:0] r, input logic [CH-1:0] b, input logic f);
        req    = r;
        bit_in = b;
        flush  = f;
    endtask

    // Present one bit on a channel and hold it until its grant is observed.
    task automatic sendBit(input int ch, input logic b);
        bit got;
        got = 1'b0;
        req[ch]    = 1'b1;
        bit_in[ch] = b;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (grant[ch]) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("[TB] FAIL grant_timeout: channel %0d got no grant, expected one within 20 cycles", ch);
        end
    endtask

    // Model update: serve the next requester in rotation order, skipping the
    // one served last cycle, and advance that stream's match progress.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CH; i++) m_prog[i] = 0;
            m_ptr = CH - 1; m_last = -1;
            m_grant = 0; m_found = 0; m_fch = 0; m_count = 0;
        end else if (flush) begin
            for (int i = 0; i < CH; i++) m_prog[i] = 0;
            m_last = -1; m_grant = 0; m_found = 0; m_fch = 0;
        end else begin
            int winner;
            int c;
            winner = -1;
            for (int k = 1; k <= CH; k++) begin
                c = (m_ptr + k) % CH;
                if (winner < 0 && req[c] === 1'b1 && c != m_last) winner = c;
            end
            m_found = 0;
            if (winner < 0) begin
                m_grant = 0;
                m_last  = -1;
            end else begin
                int want;
                int b;
                m_grant = 1 << winner;
                m_last  = winner;
                m_ptr   = winner;
                b    = int'(bit_in[winner]);
                want = int'(PAT[PLEN-1-m_prog[winner]]);
                if (b == want && m_prog[winner] == PLEN-1) begin
                    m_found = 1;
                    m_fch   = winner;
                    m_prog[winner] = 0;
                    if (m_count < 255) m_count = m_count + 1;
                end else if (b == want) begin
                    m_prog[winner] = m_prog[winner] + 1;
                end else begin
                    m_prog[winner] = (b == int'(PAT[PLEN-1])) ? 1 : 0;
                end
            end
        end
    end

    // Cycle-by-cycle comparison of the DUT outputs against the model.
    always @(negedge clk) begin
        checkOutput("model_grant", int'(grant), m_grant);
        checkOutput("model_found", int'(found), m_found);
        checkOutput("model_count", int'(match_count), m_count);
        if (m_found == 1) checkOutput("model_found_ch", int'(found_ch), m_fch);
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected it to finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus with hand-computed expectations.
    initial begin
        logic [5:0] seq;

        reset = 1'b1;
        applyStimulus(4'b1111, 4'b1111, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("reset_grant", int'(grant), 0);
        checkOutput("reset_found", int'(found), 0);
        checkOutput("reset_found_ch", int'(found_ch), 0);
        checkOutput("reset_count", int'(match_count), 0);
        reset = 1'b0;

        // Full contention: rotation 0,1,2,3 and one match per channel on grants 9-12.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checkOutput("rr_grant", int'(grant), 1 << (i % 4));
            checkOutput("rr_found", int'(found), (i >= 8) ? 1 : 0);
            if (i >= 8) checkOutput("rr_found_ch", int'(found_ch), i - 8);
        end
        checkOutput("rr_count", int'(match_count), 4);

        // Single channel: served only every other edge.
        applyStimulus(4'b0001, 4'b0001, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            checkOutput("single_grant", int'(grant), (i % 2 == 1) ? 1 : 0);
            checkOutput("single_found", int'(found), (i == 5) ? 1 : 0);
        end
        checkOutput("single_count", int'(match_count), 5);
        applyStimulus(4'b0000, 4'b0000, 1'b0);

        // Mismatch recovery on channel 1: 1,1,0,1,1,1.
        seq = 6'b110111;
        for (int i = 0; i < 6; i++) begin
            sendBit(1, seq[5-i]);
            checkOutput("mismatch_found", int'(found), (i == 5) ? 1 : 0);
        end
        checkOutput("mismatch_found_ch", int'(found_ch), 1);
        checkOutput("mismatch_count", int'(match_count), 6);
        req[1] = 1'b0;

        // Flush wins over a pending request and wipes partial progress.
        sendBit(0, 1'b1);
        sendBit(0, 1'b1);
        applyStimulus(4'b0001, 4'b0001, 1'b1);
        @(negedge clk);
        checkOutput("flush_grant", int'(grant), 0);
        checkOutput("flush_found", int'(found), 0);
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sendBit(0, 1'b1);
            checkOutput("flush_found_after", int'(found), (i == 2) ? 1 : 0);
        end
        checkOutput("flush_count", int'(match_count), 7);

        // Saturation: far more than 256 matches under full contention.
        applyStimulus(4'b1111, 4'b1111, 1'b0);
        repeat (800) @(negedge clk);
        checkOutput("sat_count", int'(match_count), 255);
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        @(negedge clk);
        flush = 1'b0;

        // Mid-stream asynchronous reset with channel 2 two bits into a match.
        sendBit(2, 1'b1);
        sendBit(2, 1'b1);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_grant", int'(grant), 0);
        checkOutput("async_found", int'(found), 0);
        checkOutput("async_found_ch", int'(found_ch), 0);
        checkOutput("async_count", int'(match_count), 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sendBit(2, 1'b1);
            checkOutput("post_reset_grant", int'(grant), 4);
            checkOutput("post_reset_found", int'(found), (i == 2) ? 1 : 0);
        end
        checkOutput("post_reset_found_ch", int'(found_ch), 2);
        checkOutput("post_reset_count", int'(match_count), 1);
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
